prog_loader: RTL
================

# prog_loader

Program loader and run controller for the multicycle CPU. It buffers a program image pushed by a host/bench stream and writes it word-by-word into CPU instruction memory through `PC_Value`/`Ins_Input` while holding the CPU in `CLR`. It then releases the CPU in one of three modes: run-to-halt, fixed cycle budget, or single-step. It replaces hand-driven `PC_Value`/`Ins_Input`/`CLR` stimulus and is parametrised in word width, address width, buffer depth and budget width.

## Interface

- `DATA_W`, 32, instruction word width
- `ADDR_W`, 32, instruction address width
- `DEPTH`, 64, program buffer depth in words (power of two, ≥2)
- `CYC_W`, 16, cycle budget / cycle counter width

- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  host word valid
- `in_ready`  out  1  loader accepts word
- `in_data`  in  DATA_W  host instruction word
- `base_addr`  in  ADDR_W  load base byte address, sampled on `go`
- `mode`  in  2  0 run-to-halt, 1 budget, 2 single-step, 3 treated as 0; sampled on `go`
- `budget`  in  CYC_W  cycle budget for mode 1, sampled on `go`
- `go`  in  1  start pulse (IDLE only)
- `step`  in  1  single-step request pulse
- `abort`  in  1  return to IDLE
- `cpu_halt`  in  1  CPU halt indication
- `PC_Value`  out  ADDR_W  instruction memory write address
- `Ins_Input`  out  DATA_W  instruction memory write data
- `ins_we`  out  1  instruction memory write enable
- `CLR`  out  1  CPU hold/clear
- `cpu_en`  out  1  CPU clock enable
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `halted`  out  1  last run ended by `cpu_halt` (sticky until next `go`)
- `overflow`  out  1  host pushed while buffer full (sticky until next `go`)
- `words`  out  $clog2(DEPTH)+1  words currently buffered
- `cyc_count`  out  CYC_W  cpu_en cycles in current/last run, saturating

## Operation

- All outputs registered. Reset: `CLR`=1, `in_ready`=1, all other outputs 0, state IDLE, buffer empty.
- States: IDLE, LOAD, RUN, STEP_WAIT, DONE.
- IDLE: `CLR`=1, `cpu_en`=0. `in_ready`=1 while `words`<DEPTH. Word stored on `in_valid && in_ready`. `in_valid` while full: word dropped, `overflow`←1.
- `go` in IDLE: latch `base_addr`, `mode`, `budget`; clear `halted`, `overflow`, `cyc_count`; `in_ready`←0. A word accepted on the `go` cycle is included. If `words`=0, skip LOAD. `go` outside IDLE is ignored.
- LOAD: one word per cycle in buffer order; word i drives `PC_Value`=base+4·i (mod 2^ADDR_W), `Ins_Input`=word i, `ins_we`=1, `CLR`=1. After last word → RUN (mode 0/1) or STEP_WAIT (mode 2); buffer empties.
- RUN: `CLR`=0, `cpu_en`=1 each cycle, `cyc_count`++ (saturates at all-ones). Mode 0: exits on `cpu_halt`. Mode 1: exits after exactly `budget` enabled cycles or on `cpu_halt`, whichever is first; `budget`=0 → DONE without any `cpu_en`.
- STEP_WAIT: `CLR`=0, `cpu_en`=0; `step` gives exactly one `cpu_en` cycle (`step` held high gives one per cycle). `cpu_halt` → DONE.
- `cpu_halt` sets `halted`. Halt and budget expiry in the same cycle: DONE, `halted`=1.
- DONE: `done`=1 for one cycle, `cpu_en`=0, then IDLE (`CLR`←1, `in_ready`←1).
- `abort` in LOAD/RUN/STEP_WAIT/DONE: next state IDLE, buffer cleared, `ins_we`=0, `cpu_en`=0, `CLR`=1, no `done`. `abort` beats `cpu_halt`/`go` in the same cycle.
- Async `RST` mid-operation: immediate return to reset values; partial load is not resumed.

## Timing

- `go` at edge t with N words: `ins_we` high on cycles t+1..t+N; first `cpu_en` at t+N+1.
- `go` with N=0: `cpu_en` at t+1 (mode 0/1).
- Mode 1, budget B: `cpu_en` high B consecutive cycles; `done` on the cycle after the last one.
- `cpu_halt` sampled at edge h: `cpu_en` low from h+1; `done` at h+1.
- `step` at edge s: `cpu_en` high s+1 only.
- `in_ready` reflects `words` from the previous edge; no combinational in→out paths.

## Test plan

- Reset then push 3 words 0x20010005,0x20020007,0x00221820, `go` with base 0x0, mode 1, budget 4 → writes at PC 0x0/0x4/0x8 on three consecutive cycles with `CLR`=1; then 4 `cpu_en` cycles; `done` pulse; `cyc_count`=4, `halted`=0.
- Fill DEPTH words plus one extra push → `in_ready`=0 at DEPTH, `overflow`=1, `words`=DEPTH; `go` loads exactly DEPTH words and clears `overflow`.
- Mode 0, `cpu_halt` asserted after 10 run cycles → `cpu_en` low the next cycle, `done` pulse, `halted`=1, `cyc_count`=10.
- Mode 2, three `step` pulses spaced 5 cycles apart, then `cpu_halt` → exactly 3 `cpu_en` cycles; `done` follows halt; `CLR`=0 throughout STEP_WAIT.
- `abort` during LOAD after 2 of 5 words → `ins_we` low next cycle, IDLE, `words`=0, `CLR`=1, no `done`; async `RST` mid-RUN → all outputs at reset values without a clock edge.
- Base 0xFFFFFFFC with 2 words → addresses 0xFFFFFFFC then 0x00000000; mode 1 budget 0 → `done` with no `cpu_en`.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader and run controller: buffers a host program image, writes it into CPU
// instruction memory while CLR holds the CPU, then runs it to halt, for a budget, or by steps.
module prog_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int CYC_W  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [1:0]             mode,
  input  logic [CYC_W-1:0]       budget,
  input  logic                   go,
  input  logic                   step,
  input  logic                   abort,
  input  logic                   cpu_halt,
  output logic [ADDR_W-1:0]      PC_Value,
  output logic [DATA_W-1:0]      Ins_Input,
  output logic                   ins_we,
  output logic                   CLR,
  output logic                   cpu_en,
  output logic                   busy,
  output logic                   done,
  output logic                   halted,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] words,
  output logic [CYC_W-1:0]       cyc_count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STEP_WAIT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [CYC_W-1:0]  budget_q;
  logic [CYC_W-1:0]  rem_q;
  logic [CNT_W-1:0]  words_q;
  logic [CNT_W-1:0]  ld_idx_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ins_q;
  logic              ins_we_q, clr_q, cpu_en_q, busy_q, done_q;
  logic              halted_q, overflow_q, in_ready_q;
  logic [CYC_W-1:0]  cyc_q;

  logic              accept, go_fire, start_run;
  logic [CNT_W-1:0]  words_d;
  logic [1:0]        go_mode, run_mode;
  logic [CYC_W-1:0]  run_budget;
  state_e            run_state;

  // Run parameters come straight from the inputs when starting from IDLE (empty buffer),
  // otherwise from the values latched at go.
  always_comb begin
    // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
    accept     = (state_q == S_IDLE) && in_valid && in_ready_q;
    words_d    = words_q + CNT_W'(accept);
    go_fire    = (state_q == S_IDLE) && go && !abort;
    go_mode    = (mode == 2'd3) ? 2'd0 : mode;
    run_mode   = (state_q == S_IDLE) ? go_mode : mode_q;
    run_budget = (state_q == S_IDLE) ? budget : budget_q;
    start_run  = (go_fire && (words_d == '0)) ||
                 ((state_q == S_LOAD) && !abort && (ld_idx_q == words_q));
    if (run_mode == 2'd2)                            run_state = S_STEP_WAIT;
    else if ((run_mode == 2'd1) && (run_budget == '0)) run_state = S_DONE;
    else                                             run_state = S_RUN;
  end

  // NOTE: the program buffer is not reset; words_q alone marks which entries are valid.
  always_ff @(posedge CLK) begin
    if (accept) mem_q[words_q[IDX_W-1:0]] <= in_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      budget_q   <= '0;
      rem_q      <= '0;
      words_q    <= '0;
      ld_idx_q   <= '0;
      pc_q       <= '0;
      ins_q      <= '0;
      ins_we_q   <= 1'b0;
      clr_q      <= 1'b1;
      cpu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b1;
      cyc_q      <= '0;
    end else begin
      ins_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (cpu_en_q && (cyc_q != '1)) cyc_q <= cyc_q + 1'b1;

      unique case (state_q)
        S_IDLE: begin
          words_q    <= words_d;
          in_ready_q <= (words_d != FULL);
          if (in_valid && !in_ready_q) overflow_q <= 1'b1;
          if (go_fire) begin
            mode_q     <= go_mode;
            budget_q   <= budget;
            pc_q       <= base_addr;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
            cyc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            ins_we_q   <= 1'b1;
            // A lone word accepted on the go edge is not in the buffer yet.
            ins_q      <= (words_q == '0) ? in_data : mem_q[0];
            ld_idx_q   <= CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (ld_idx_q != words_q) begin
            ins_we_q <= 1'b1;
            ins_q    <= mem_q[ld_idx_q[IDX_W-1:0]];
            pc_q     <= pc_q + ADDR_W'(4);
            ld_idx_q <= ld_idx_q + 1'b1;
          end
        end
        S_RUN: begin
          rem_q <= rem_q - 1'b1;
          if (cpu_halt) begin
            halted_q <= 1'b1;
            state_q  <= S_DONE;
            cpu_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else if ((mode_q == 2'd1) && (rem_q == CYC_W'(1))) begin
            state_q  <= S_DONE;
            cpu_en_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        S_STEP_WAIT: begin
          if (cpu_halt) begin
            halted_q <= 1'b1;
            state_q  <= S_DONE;
            cpu_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cpu_en_q <= step;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          clr_q      <= 1'b1;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (start_run) begin
        state_q    <= run_state;
        words_q    <= '0;
        rem_q      <= run_budget;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b1;
        clr_q      <= 1'b0;
        ins_we_q   <= 1'b0;
        cpu_en_q   <= (run_state == S_RUN);
        done_q     <= (run_state == S_DONE);
      end

      // Abort overrides everything decided above, including a same-cycle halt.
      if (abort && (state_q != S_IDLE)) begin
        state_q    <= S_IDLE;
        words_q    <= '0;
        ins_we_q   <= 1'b0;
        cpu_en_q   <= 1'b0;
        clr_q      <= 1'b1;
        done_q     <= 1'b0;
        halted_q   <= halted_q;
        in_ready_q <= 1'b1;
        busy_q     <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign PC_Value  = pc_q;
  assign Ins_Input = ins_q;
  assign ins_we    = ins_we_q;
  assign CLR       = clr_q;
  assign cpu_en    = cpu_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign halted    = halted_q;
  assign overflow  = overflow_q;
  assign words     = words_q;
  assign cyc_count = cyc_q;

endmodule
